// File: rtl/ltc_2656_pkg.sv
// Shared constants for the LTC-2656 update sequencer: command codes, broadcast
// address and FSM state encoding.
package ltc_2656_pkg;

  localparam logic [3:0] CMD_WRITE_N       = 4'b0000;
  localparam logic [3:0] CMD_UPDATE_N      = 4'b0001;
  localparam logic [3:0] CMD_WRITE_UPD_ALL = 4'b0010;
  localparam logic [3:0] CMD_WRITE_UPD_N   = 4'b0011;
  localparam logic [3:0] CMD_PWRDN_N       = 4'b0100;
  localparam logic [3:0] CMD_PWRDN_ALL     = 4'b0101;
  localparam logic [3:0] CMD_REF_INT       = 4'b0110;
  localparam logic [3:0] CMD_REF_EXT       = 4'b0111;
  localparam logic [3:0] CMD_NOP           = 4'b1111;

  localparam logic [3:0] ADDR_ALL = 4'hF;

  localparam logic [3:0] S_INIT      = 4'd0;
  localparam logic [3:0] S_INIT_WAIT = 4'd1;
  localparam logic [3:0] S_IDLE      = 4'd2;
  localparam logic [3:0] S_SCAN      = 4'd3;
  localparam logic [3:0] S_WAIT      = 4'd4;
  localparam logic [3:0] S_LDAC      = 4'd5;
  localparam logic [3:0] S_LWAIT     = 4'd6;
  localparam logic [3:0] S_DONE      = 4'd7;
  localparam logic [3:0] S_CLR       = 4'd8;
  localparam logic [3:0] S_CLR_WAIT  = 4'd9;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [15:0] data;
  } dac_word_t;

  function automatic logic [3:0] ref_select_cmd(input bit use_int_ref);
    return use_int_ref ? CMD_REF_INT : CMD_REF_EXT;
  endfunction

endpackage

// File: rtl/ltc_2656_dirty_pick.sv
// Finds the lowest dirty channel at or above the scan pointer.
// A pointer of 8 masks everything, signalling the scan is exhausted.
module ltc_2656_dirty_pick (
  input  logic [7:0] i_dirty,
  input  logic [3:0] i_ptr,
  output logic       o_found,
  output logic [2:0] o_idx
);

  always_comb begin
    o_found = 1'b0;
    o_idx   = 3'd0;
    // Descending walk so the last hit is the lowest qualifying index
    for (int i = 7; i >= 0; i--) begin
      if (i_dirty[i] && (4'(i) >= i_ptr)) begin
        o_found = 1'b1;
        o_idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/ltc_2656_update_seq.sv
// Shadow-register sequencer for the LTC-2656 SPI driver: flushes dirty channels
// on commit followed by a single LDAC, and handles reference select and CLR.
module ltc_2656_update_seq
  import ltc_2656_pkg::*;
#(
  parameter bit USE_INT_REF = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  input  logic [2:0]  i_wr_channel,
  input  logic [15:0] i_wr_value,
  input  logic        i_commit,
  input  logic        i_clear,
  output logic        o_busy,
  output logic        o_done,
  output logic [3:0]  o_dac_cmd,
  output logic [3:0]  o_dac_channel,
  output logic [15:0] o_dac_value,
  output logic        o_dac_start,
  output logic        o_dac_ldac,
  output logic        o_dac_clr,
  input  logic        i_dac_idle
);

  logic [3:0]  r_state;
  logic [15:0] r_shadow [8];
  logic [7:0]  r_dirty;
  logic [3:0]  r_ptr;
  logic        r_sent;
  logic        r_commit_pend;
  logic        r_clear_pend;

  logic        r_busy, r_wr_ready, r_done;
  logic        r_dac_start, r_dac_ldac, r_dac_clr;
  logic [3:0]  r_dac_cmd, r_dac_channel;
  logic [15:0] r_dac_value;

  logic [3:0]  w_state_next;
  logic [3:0]  w_ptr_next;
  logic        w_sent_next;
  logic [3:0]  w_cmd_next, w_channel_next;
  logic [15:0] w_value_next;
  logic        w_start_next, w_ldac_next, w_clr_next, w_done_next;
  logic [7:0]  w_dirty_clr;
  logic [7:0]  w_dirty_set;
  logic        w_shadow_zero;
  logic        w_commit_take;
  logic        w_wr_fire;
  logic        w_commit_eff, w_clear_eff;
  logic        w_found;
  logic [2:0]  w_idx;

  ltc_2656_dirty_pick u_pick (
    .i_dirty (r_dirty),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  assign w_wr_fire    = i_wr_valid & r_wr_ready;
  assign w_dirty_set  = w_wr_fire ? (8'd1 << i_wr_channel) : 8'd0;
  // A request arriving in the same cycle as IDLE is acted on immediately
  assign w_commit_eff = r_commit_pend | i_commit;
  assign w_clear_eff  = r_clear_pend  | i_clear;

  always_comb begin
    w_state_next   = r_state;
    w_ptr_next     = r_ptr;
    w_sent_next    = r_sent;
    w_cmd_next     = r_dac_cmd;
    w_channel_next = r_dac_channel;
    w_value_next   = r_dac_value;
    w_start_next   = 1'b0;
    w_ldac_next    = 1'b0;
    w_clr_next     = 1'b0;
    w_done_next    = 1'b0;
    w_dirty_clr    = 8'd0;
    w_shadow_zero  = 1'b0;
    w_commit_take  = 1'b0;
    case (r_state)
      S_INIT: begin
        if (i_dac_idle) begin
          w_cmd_next     = ref_select_cmd(USE_INT_REF);
          w_channel_next = ADDR_ALL;
          w_value_next   = 16'd0;
          w_start_next   = 1'b1;
          w_state_next   = S_INIT_WAIT;
        end
      end
      S_INIT_WAIT: if (i_dac_idle) w_state_next = S_IDLE;
      S_IDLE: begin
        if (w_clear_eff) begin
          w_state_next = S_CLR;
        end else if (w_commit_eff) begin
          w_state_next  = S_SCAN;
          w_ptr_next    = 4'd0;
          w_sent_next   = 1'b0;
          w_commit_take = 1'b1;
        end
      end
      S_SCAN: begin
        if (w_found) begin
          w_cmd_next     = CMD_WRITE_N;
          w_channel_next = {1'b0, w_idx};
          w_value_next   = r_shadow[w_idx];
          w_start_next   = 1'b1;
          w_dirty_clr    = 8'd1 << w_idx;
          w_ptr_next     = {1'b0, w_idx} + 4'd1;
          w_sent_next    = 1'b1;
          w_state_next   = S_WAIT;
        end else begin
          w_state_next = r_sent ? S_LDAC : S_DONE;
        end
      end
      S_WAIT: if (i_dac_idle) w_state_next = S_SCAN;
      S_LDAC: begin
        w_ldac_next  = 1'b1;
        w_state_next = S_LWAIT;
      end
      S_LWAIT: if (i_dac_idle) w_state_next = S_DONE;
      S_DONE: begin
        w_done_next  = 1'b1;
        w_state_next = S_IDLE;
      end
      S_CLR: begin
        w_clr_next    = 1'b1;
        w_shadow_zero = 1'b1;
        w_state_next  = S_CLR_WAIT;
      end
      S_CLR_WAIT: if (i_dac_idle) w_state_next = S_IDLE;
      default: w_state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_INIT;
      r_dirty       <= 8'd0;
      r_ptr         <= 4'd0;
      r_sent        <= 1'b0;
      r_commit_pend <= 1'b0;
      r_clear_pend  <= 1'b0;
      r_busy        <= 1'b1;
      r_wr_ready    <= 1'b0;
      r_done        <= 1'b0;
      r_dac_cmd     <= CMD_NOP;
      r_dac_channel <= 4'd0;
      r_dac_value   <= 16'd0;
      r_dac_start   <= 1'b0;
      r_dac_ldac    <= 1'b0;
      r_dac_clr     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_sent  <= w_sent_next;
      // Write wins over a same-cycle dispatch of the same channel
      r_dirty <= w_shadow_zero ? 8'd0 : ((r_dirty & ~w_dirty_clr) | w_dirty_set);

      if (w_commit_take)        r_commit_pend <= 1'b0;
      else if (i_commit)        r_commit_pend <= 1'b1;
      else if (r_state == S_CLR) r_commit_pend <= 1'b0;

      if (i_clear)              r_clear_pend <= 1'b1;
      else if (r_state == S_CLR) r_clear_pend <= 1'b0;

      r_busy     <= (w_state_next != S_IDLE);
      r_wr_ready <= !((w_state_next == S_INIT) || (w_state_next == S_INIT_WAIT) ||
                      (w_state_next == S_CLR)  || (w_state_next == S_CLR_WAIT));
      r_done        <= w_done_next;
      r_dac_cmd     <= w_cmd_next;
      r_dac_channel <= w_channel_next;
      r_dac_value   <= w_value_next;
      r_dac_start   <= w_start_next;
      r_dac_ldac    <= w_ldac_next;
      r_dac_clr     <= w_clr_next;
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_shadow
    always_ff @(posedge clk) begin
      if (!resetn || w_shadow_zero) begin
        r_shadow[gi] <= 16'd0;
      end else if (w_wr_fire && (i_wr_channel == 3'(gi))) begin
        r_shadow[gi] <= i_wr_value;
      end
    end
  end

  assign o_wr_ready    = r_wr_ready;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_dac_cmd     = r_dac_cmd;
  assign o_dac_channel = r_dac_channel;
  assign o_dac_value   = r_dac_value;
  assign o_dac_start   = r_dac_start;
  assign o_dac_ldac    = r_dac_ldac;
  assign o_dac_clr     = r_dac_clr;

endmodule

// File: tb/tb_ltc_2656_update_seq.sv
// Scoreboard bench for ltc_2656_update_seq with a behavioural stand-in for the
// SPI driver's idle handshake.
module tb_ltc_2656_update_seq;

  localparam logic [1:0] K_START = 2'd0;
  localparam logic [1:0] K_LDAC  = 2'd1;
  localparam logic [1:0] K_CLR   = 2'd2;
  localparam logic [1:0] K_DONE  = 2'd3;
  localparam int DRV_BUSY = 20;

  typedef struct packed {
    logic [1:0]  kind;
    logic [23:0] word;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wr_valid, wr_ready;
  logic [2:0]  wr_channel;
  logic [15:0] wr_value;
  logic        commit, clear;
  logic        busy, done;
  logic [3:0]  dac_cmd, dac_channel;
  logic [15:0] dac_value;
  logic        dac_start, dac_ldac, dac_clr, dac_idle;
  logic [5:0]  drv_cnt;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ltc_2656_update_seq #(.USE_INT_REF(1'b1)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .i_wr_valid    (wr_valid),
    .o_wr_ready    (wr_ready),
    .i_wr_channel  (wr_channel),
    .i_wr_value    (wr_value),
    .i_commit      (commit),
    .i_clear       (clear),
    .o_busy        (busy),
    .o_done        (done),
    .o_dac_cmd     (dac_cmd),
    .o_dac_channel (dac_channel),
    .o_dac_value   (dac_value),
    .o_dac_start   (dac_start),
    .o_dac_ldac    (dac_ldac),
    .o_dac_clr     (dac_clr),
    .i_dac_idle    (dac_idle)
  );

  // Driver stand-in: idle drops with the request pulse and stays low a while
  always @(posedge clk) begin
    if (!resetn) drv_cnt <= '0;
    else if (dac_start || dac_ldac || dac_clr) drv_cnt <= 6'(DRV_BUSY);
    else if (drv_cnt != 0) drv_cnt <= drv_cnt - 6'd1;
  end
  assign dac_idle = (drv_cnt == 0) && !(dac_start || dac_ldac || dac_clr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [23:0] word);
    exp_t e;
    e.kind = kind;
    e.word = word;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [1:0] kind, input logic [23:0] word);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d word %h expected nothing", kind, word);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || (kind == K_START && e.word != word)) begin
        errors++;
        $display("FAIL event: got kind %0d word %h expected kind %0d word %h",
                 kind, word, e.kind, e.word);
      end else if (kind == K_START) begin
        $display("start word %h", word);
      end else begin
        $display("event kind %0d", kind);
      end
    end
  endtask

  // Monitor: every request/done pulse is matched against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (dac_start) pop_check(K_START, {dac_cmd, dac_channel, dac_value});
      if (dac_ldac)  pop_check(K_LDAC, 24'd0);
      if (dac_clr)   pop_check(K_CLR, 24'd0);
      if (done)      pop_check(K_DONE, 24'd0);
    end
  end

  task automatic write_ch(input logic [2:0] ch, input logic [15:0] v);
    bit ok = 0;
    wr_valid = 1'b1;
    wr_channel = ch;
    wr_value = v;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (wr_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
      end
    end
    wr_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL write_timeout: got no wr_ready expected accept of ch %0d", ch);
    end
  endtask

  task automatic pulse_commit();
    @(posedge clk); #1 commit = 1'b1;
    @(posedge clk); #1 commit = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
  endtask

  task automatic wait_settled(input string name);
    bit ok = 0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0 && dac_idle) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got busy %0d pending %0d expected settled", name, busy, sb.size());
    end
  endtask

  task automatic wait_start(input string name);
    bit ok = 0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      if (dac_start) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_start_timeout: got no start expected one", name);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},     32'(busy), 32'd1);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
    chk({tag, "_cmd"},      32'(dac_cmd), 32'hF);
    chk({tag, "_channel"},  32'(dac_channel), 32'd0);
    chk({tag, "_value"},    32'(dac_value), 32'd0);
    chk({tag, "_pulses"},   32'({dac_start, dac_ldac, dac_clr, done}), 32'd0);
  endtask

  initial begin
    int n;
    resetn = 1'b0; wr_valid = 1'b0; wr_channel = '0; wr_value = '0;
    commit = 1'b0; clear = 1'b0;

    // Reset values, then the internal-reference init word
    repeat (4) @(posedge clk);
    #1 check_reset_outputs("rst");
    push(K_START, 24'h6F0000);
    resetn = 1'b1;
    wait_settled("init");
    chk("init_wr_ready", 32'(wr_ready), 32'd1);
    chk("init_busy", 32'(busy), 32'd0);

    // Two channels in ascending order, then one LDAC and done
    write_ch(3'd2, 16'h1234);
    write_ch(3'd5, 16'hABCD);
    push(K_START, 24'h021234);
    push(K_START, 24'h05ABCD);
    push(K_LDAC, 24'd0);
    push(K_DONE, 24'd0);
    pulse_commit();
    wait_settled("flush2");

    // Empty commit: done only, within 3 cycles
    push(K_DONE, 24'd0);
    @(posedge clk); #1 commit = 1'b1;
    n = 0;
    for (int k = 1; k <= 10 && n == 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) commit = 1'b0;
      if (done) n = k;
    end
    chk("empty_done_within_3", 32'(n >= 1 && n <= 3), 32'd1);
    wait_settled("empty");

    // Channel pointer boundary: ch0 and ch7 both sent, lowest first
    write_ch(3'd7, 16'h7777);
    write_ch(3'd0, 16'h0007);
    push(K_START, 24'h000007);
    push(K_START, 24'h077777);
    push(K_LDAC, 24'd0);
    push(K_DONE, 24'd0);
    pulse_commit();
    wait_settled("edges");

    // Writes during the ch0 transfer: ch1 goes now, ch0 waits for next commit
    write_ch(3'd0, 16'h1111);
    push(K_START, 24'h001111);
    push(K_START, 24'h010001);
    push(K_LDAC, 24'd0);
    push(K_DONE, 24'd0);
    pulse_commit();
    wait_start("midflush");
    write_ch(3'd0, 16'h5555);
    write_ch(3'd1, 16'h0001);
    wait_settled("midflush");
    push(K_START, 24'h005555);
    push(K_LDAC, 24'd0);
    push(K_DONE, 24'd0);
    pulse_commit();
    wait_settled("redirty");

    // Clear mid-flush: flush and LDAC finish first, then CLR
    write_ch(3'd3, 16'h0333);
    write_ch(3'd6, 16'h0666);
    push(K_START, 24'h030333);
    push(K_START, 24'h060666);
    push(K_LDAC, 24'd0);
    push(K_DONE, 24'd0);
    push(K_CLR, 24'd0);
    pulse_commit();
    wait_start("clr");
    pulse_clear();
    wait_settled("clr");
    push(K_DONE, 24'd0);
    pulse_commit();
    wait_settled("post_clr");

    // Reset while waiting on the driver: outputs return to reset values
    write_ch(3'd4, 16'h4444);
    push(K_START, 24'h044444);
    pulse_commit();
    wait_start("rst_mid");
    @(posedge clk); #1 resetn = 1'b0;
    @(posedge clk); #1 check_reset_outputs("midrst");
    push(K_START, 24'h6F0000);
    @(posedge clk); #1 resetn = 1'b1;
    wait_settled("reinit");
    push(K_DONE, 24'd0);
    pulse_commit();
    wait_settled("post_reset");

    repeat (30) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
